video_timing_detect: RTL and testbench
======================================

# video_timing_detect

Sink-side counterpart of the video timing generator. Accepts an incoming HS/VS/DE/RGB stream, recovers per-pixel X/Y coordinates, line and frame markers, and measures the frame geometry (active and total width/height). It declares lock once the geometry has been stable for a set number of frames. It sits between a video source (camera/HDMI receiver/timing generator) and pixel-processing stages that need coordinates and a trusted resolution.

## Interface
- CNT_W, 13: width of total/measurement counters (horizontal clocks, vertical lines).
- H_SYNC_LVL, 0: level of i_hs during the sync pulse.
- V_SYNC_LVL, 0: level of i_vs during the sync pulse.
- LOCK_FRAMES, 2: consecutive matching frame comparisons required for lock (1..15).
- i_clk  in  1  pixel clock; the only clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_hs, i_vs, i_de  in  1 each  incoming syncs and data enable.
- i_rgb  in  24  incoming pixel.
- o_hs, o_vs, o_de  out  1 each  syncs/DE delayed 2 cycles.
- o_rgb  out  24  i_rgb delayed 2 cycles; 0 when o_de=0.
- o_x_pos, o_y_pos  out  11 each  coordinates of the pixel on o_rgb.
- o_sof  out  1  pulse with first active pixel of a frame.
- o_eol  out  1  pulse with last active pixel of each line.
- o_h_active, o_v_active  out  11 each  measured active width/height of last completed frame.
- o_h_total, o_v_total  out  CNT_W each  clocks per line, lines per frame.
- o_locked  out  1  geometry stable.

## Operation
- Input pipeline: s1 registers inputs; s2 registers s1. Outputs are driven from s2 (plus edge info from s1 vs s2).
- Sync leading edge = transition of the sampled sync into its *_SYNC_LVL.
- h_clk counter: cleared to 1 on HS leading edge, otherwise +1, saturates at 2^CNT_W-1. At each HS leading edge its value becomes line_total.
- Per line: active pixel count pix_cnt (+1 per DE cycle, cleared on DE rise). On DE fall, line width is compared with the first line width of the frame; any difference sets frame_bad.
- Per frame, between VS leading edges: lines counted on HS leading edges (v_total); DE falls counted (v_active); first line width gives h_active; line_total must be equal on all lines, else frame_bad.
- At each VS leading edge: the four measurements are published to o_h_active/o_v_active/o_h_total/o_v_total, compared with the previously stored frame, then stored. Counters and frame_bad clear.
- A frame matches when all four values are equal to the stored frame, frame_bad=0, and no counter saturated.
- FSM:
  - IDLE: o_locked=0. On first VS edge, go to ACQ; stored frame=0 and match_cnt=0.
  - ACQ: at each VS edge, a match increments match_cnt, otherwise match_cnt=0. When match_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: o_locked=1. A mismatching frame returns to ACQ with match_cnt=0.
  - Watchdog, any state: if h_clk saturates, go to IDLE, o_locked=0, and all measurement outputs=0.
- X/Y:
  - o_x_pos=0 on the first DE pixel of a line, +1 per DE pixel.
  - o_y_pos=0 for the first active line after a VS edge, +1 per subsequent active line.
  - Both wrap modulo 2048. Both hold their value while o_de=0.
- o_sof = o_de & x=0 & y=0, asserted once per frame.
- o_eol = s2 DE=1 & s1 DE=0.

## Timing
- All outputs reset to 0 asynchronously. FSM resets to IDLE. Reset mid-line or mid-frame discards the partial frame.
- Latency: o_hs/o_vs/o_de/o_rgb/o_x_pos/o_y_pos/o_sof/o_eol are exactly 2 cycles after the inputs.
- Measurement outputs and o_locked update 1 cycle after the VS leading edge appears at s2 (3 cycles after i_vs).
- Simultaneous HS and VS leading edges: the line closes first, then the frame closes using that line's values.
- A DE fall coinciding with a VS edge counts in the closing frame.
- Single-cycle DE pulse: o_sof/o_eol both assert on that pixel.

## Test plan
- Reset, then stable timing (active 16x4; h: fp2/sync2/bp4, total 24; v: fp1/sync1/bp2, total 8) -> measurements 16/4/24/8 published after the 2nd VS edge; o_locked rises 1 cycle after the 4th VS edge.
- Same stream, locked -> per frame, o_x_pos 0..15 and o_y_pos 0..3 aligned to o_de; one o_sof (x=0,y=0); four o_eol at x=15; o_rgb equals i_rgb from 2 cycles earlier.
- Switch to 20 active (total 28) while locked -> o_locked falls 1 cycle after the first VS edge closing a changed frame; relocks after 2 further matching frames.
- One line with 15 DE pixels inside an otherwise valid frame -> frame_bad set, lock lost at that frame's closing VS edge, o_h_active stays 16.
- HS held inactive for 8191+ cycles -> o_locked=0 and measurements=0 on saturation; normal stream afterwards relocks like after reset.
- i_rst_n pulsed low mid-line -> all outputs 0 immediately; no o_de/o_sof until stream continues; o_y_pos starts at 0 after the first VS edge.

Source files
------------

// File: rtl/video_timing_detect.sv
// Sink-side video timing detector: recovers pixel coordinates and line/frame markers from an
// HS/VS/DE stream, measures frame geometry and declares lock once the geometry is stable.
`timescale 1ns/1ps
module video_timing_detect #(
  parameter int   CNT_W       = 13,
  parameter logic H_SYNC_LVL  = 1'b0,
  parameter logic V_SYNC_LVL  = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_de,
  input  logic [23:0]      i_rgb,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic [23:0]      o_rgb,
  output logic [10:0]      o_x_pos,
  output logic [10:0]      o_y_pos,
  output logic             o_sof,
  output logic             o_eol,
  output logic [10:0]      o_h_active,
  output logic [10:0]      o_v_active,
  output logic [CNT_W-1:0] o_h_total,
  output logic [CNT_W-1:0] o_v_total,
  output logic             o_locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [10:0]      POS_MAX = '1;
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_LOCKED} state_t;

  logic        r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2;
  logic        r_hs_lead, r_vs_lead, r_new_frame;
  logic [23:0] r_rgb1, r_rgb2;
  logic [10:0] r_x, r_y;
  logic        w_vs_lead_s1, w_eol, w_wdog, w_match;
  logic [10:0] w_width;

  assign w_vs_lead_s1 = (r_vs1 == V_SYNC_LVL) && (r_vs2 != V_SYNC_LVL);
  assign w_eol        = r_de2 & ~r_de1;
  assign w_width      = r_x + 11'd1;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs1 <= 1'b0; r_vs1 <= 1'b0; r_de1 <= 1'b0; r_rgb1 <= '0;
      r_hs2 <= 1'b0; r_vs2 <= 1'b0; r_de2 <= 1'b0; r_rgb2 <= '0;
      r_hs_lead <= 1'b0; r_vs_lead <= 1'b0; r_new_frame <= 1'b0;
      r_x <= '0; r_y <= '0;
    end else begin
      r_hs1 <= i_hs;  r_vs1 <= i_vs;  r_de1 <= i_de;  r_rgb1 <= i_rgb;
      r_hs2 <= r_hs1; r_vs2 <= r_vs1; r_de2 <= r_de1; r_rgb2 <= r_rgb1;
      // Edge flags are registered so they line up with the s2 sample they belong to.
      r_hs_lead <= (r_hs1 == H_SYNC_LVL) && (r_hs2 != H_SYNC_LVL);
      r_vs_lead <= w_vs_lead_s1;
      if (w_vs_lead_s1) r_new_frame <= 1'b1;
      if (r_de1) begin
        if (!r_de2) begin
          r_x <= '0;
          if (r_new_frame || w_vs_lead_s1) begin
            r_y         <= '0;
            r_new_frame <= 1'b0;
          end else begin
            r_y <= r_y + 11'd1;
          end
        end else begin
          r_x <= r_x + 11'd1;
        end
      end
    end
  end

  assign o_hs    = r_hs2;
  assign o_vs    = r_vs2;
  assign o_de    = r_de2;
  assign o_rgb   = r_de2 ? r_rgb2 : 24'd0;
  assign o_x_pos = r_x;
  assign o_y_pos = r_y;
  assign o_sof   = r_de2 && (r_x == 11'd0) && (r_y == 11'd0);
  assign o_eol   = w_eol;

  logic [CNT_W-1:0] r_h_clk, r_tot_first, r_vtot, w_tot_first, w_vtot;
  logic [10:0]      r_hact, r_vact, w_hact, w_vact;
  logic             r_tot_vld, w_tot_vld, r_hact_vld, w_hact_vld;
  logic             r_frame_bad, w_bad, r_sat, w_sat;

  // Next-state frame measurements including this cycle's line events, so a frame closing on the
  // same cycle as an HS edge or last pixel already contains that line.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_tot_first = r_tot_first;
    w_tot_vld   = r_tot_vld;
    w_vtot      = r_vtot;
    w_hact      = r_hact;
    w_hact_vld  = r_hact_vld;
    w_vact      = r_vact;
    w_bad       = r_frame_bad;
    w_sat       = r_sat;
    if (r_hs_lead) begin
      if (!r_tot_vld) begin
        w_tot_first = r_h_clk;
        w_tot_vld   = 1'b1;
      end else if (r_h_clk != r_tot_first) begin
        w_bad = 1'b1;
      end
      if (r_vtot == CNT_MAX) w_sat = 1'b1;
      else                   w_vtot = r_vtot + CNT_ONE;
    end
    if (w_eol) begin
      if (!r_hact_vld) begin
        w_hact     = w_width;
        w_hact_vld = 1'b1;
      end else if (w_width != r_hact) begin
        w_bad = 1'b1;
      end
      if (r_vact == POS_MAX) w_sat = 1'b1;
      else                   w_vact = r_vact + 11'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_clk <= '0; r_tot_first <= '0; r_vtot <= '0; r_hact <= '0; r_vact <= '0;
      r_tot_vld <= 1'b0; r_hact_vld <= 1'b0; r_frame_bad <= 1'b0; r_sat <= 1'b0;
    end else begin
      if (r_hs_lead)               r_h_clk <= CNT_ONE;
      else if (r_h_clk != CNT_MAX) r_h_clk <= r_h_clk + CNT_ONE;
      if (r_vs_lead) begin
        r_tot_first <= '0; r_vtot <= '0; r_hact <= '0; r_vact <= '0;
        r_tot_vld <= 1'b0; r_hact_vld <= 1'b0; r_frame_bad <= 1'b0; r_sat <= 1'b0;
      end else begin
        r_tot_first <= w_tot_first; r_vtot <= w_vtot; r_hact <= w_hact; r_vact <= w_vact;
        r_tot_vld <= w_tot_vld; r_hact_vld <= w_hact_vld; r_frame_bad <= w_bad; r_sat <= w_sat;
      end
    end
  end

  logic [10:0]      r_st_hact, r_st_vact, r_o_hact, r_o_vact;
  logic [CNT_W-1:0] r_st_htot, r_st_vtot, r_o_htot, r_o_vtot;
  state_t           r_state;
  logic [3:0]       r_match_cnt;
  logic             r_locked;

  assign w_wdog  = (r_h_clk == CNT_MAX);
  assign w_match = (w_hact == r_st_hact) && (w_vact == r_st_vact) &&
                   (w_tot_first == r_st_htot) && (w_vtot == r_st_vtot) && !w_bad && !w_sat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE; r_match_cnt <= '0; r_locked <= 1'b0;
      r_st_hact <= '0; r_st_vact <= '0; r_st_htot <= '0; r_st_vtot <= '0;
      r_o_hact <= '0; r_o_vact <= '0; r_o_htot <= '0; r_o_vtot <= '0;
    end else if (w_wdog) begin
      r_state <= ST_IDLE; r_match_cnt <= '0; r_locked <= 1'b0;
      r_o_hact <= '0; r_o_vact <= '0; r_o_htot <= '0; r_o_vtot <= '0;
    end else if (r_vs_lead) begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_ACQ; r_match_cnt <= '0;
          r_st_hact <= '0; r_st_vact <= '0; r_st_htot <= '0; r_st_vtot <= '0;
        end
        default: begin
          r_o_hact <= w_hact; r_o_vact <= w_vact; r_o_htot <= w_tot_first; r_o_vtot <= w_vtot;
          r_st_hact <= w_hact; r_st_vact <= w_vact; r_st_htot <= w_tot_first; r_st_vtot <= w_vtot;
          if (!w_match) begin
            r_state <= ST_ACQ; r_locked <= 1'b0; r_match_cnt <= '0;
          end else if (r_state == ST_ACQ) begin
            if (r_match_cnt + 4'd1 >= LOCK_N) begin
              r_state <= ST_LOCKED; r_locked <= 1'b1; r_match_cnt <= LOCK_N;
            end else begin
              r_match_cnt <= r_match_cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign o_h_active = r_o_hact;
  assign o_v_active = r_o_vact;
  assign o_h_total  = r_o_htot;
  assign o_v_total  = r_o_vtot;
  assign o_locked   = r_locked;

endmodule

// File: tb/tb_video_timing_detect.sv
// Directed bench for video_timing_detect: frame generator with hand-computed geometry and lock timing.
`timescale 1ns/1ps
module tb_video_timing_detect;
  localparam int CNT_W = 13;

  logic             i_clk = 1'b0, i_rst_n = 1'b0, i_hs = 1'b1, i_vs = 1'b1, i_de = 1'b0;
  logic [23:0]      i_rgb = '0;
  logic             o_hs, o_vs, o_de, o_sof, o_eol, o_locked;
  logic [23:0]      o_rgb;
  logic [10:0]      o_x_pos, o_y_pos, o_h_active, o_v_active;
  logic [CNT_W-1:0] o_h_total, o_v_total;

  video_timing_detect #(.CNT_W(CNT_W), .H_SYNC_LVL(1'b0), .V_SYNC_LVL(1'b0), .LOCK_FRAMES(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_rgb(i_rgb),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_rgb(o_rgb), .o_x_pos(o_x_pos), .o_y_pos(o_y_pos),
    .o_sof(o_sof), .o_eol(o_eol), .o_h_active(o_h_active), .o_v_active(o_v_active),
    .o_h_total(o_h_total), .o_v_total(o_v_total), .o_locked(o_locked)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic [10:0] x;
    logic [10:0] y;
  } px_t;

  px_t              e1, e2, cur;
  logic [10:0]      m_x, m_y;
  int               n_pass = 0, n_chk = 0;
  bit               px_chk = 1'b0;
  int               sof_cnt, eol_cnt, eol_bad, px_err;
  logic             lk_pre, lk_post, cap_rst_any;
  logic [10:0]      cap_hact, cap_vact;
  logic [CNT_W-1:0] cap_htot, cap_vtot;

  // Shift the expected-output pipeline; outputs show the input driven two cycles earlier.
  task automatic step_model();
    if (px_chk) begin
      if (o_hs !== e2.hs || o_vs !== e2.vs || o_de !== e2.de || o_rgb !== e2.rgb ||
          o_x_pos !== e2.x || o_y_pos !== e2.y ||
          o_sof !== (e2.de && e2.x == 11'd0 && e2.y == 11'd0) || o_eol !== (e2.de && !e1.de))
        px_err++;
    end
    e2 = e1;
    e1 = cur;
  endtask

  // One frame: 8 lines of act+8 clocks; active lines 0..3, HS sync at act+2..act+3, VS sync on line 5.
  task automatic run_frame(input int act, input int bad_line, input int rst_line);
    int   tot;
    logic de_v;
    tot = act + 8;
    sof_cnt = 0; eol_cnt = 0; eol_bad = 0; px_err = 0;
    for (int ln = 0; ln < 8; ln++) begin
      for (int h = 0; h < tot; h++) begin
        de_v    = (ln < 4) && (h < ((ln == bad_line) ? act - 1 : act));
        i_hs    = !(h == act + 2 || h == act + 3);
        i_vs    = (ln != 5);
        i_de    = de_v;
        i_rgb   = 24'($urandom);
        if (de_v) begin m_x = 11'(h); m_y = 11'(ln); end
        cur.hs  = i_hs; cur.vs = i_vs; cur.de = de_v;
        cur.rgb = de_v ? i_rgb : 24'd0;
        cur.x   = m_x; cur.y = m_y;
        if (ln == rst_line && h == 5) begin
          i_rst_n = 1'b0;
          #2;
          cap_rst_any = |{o_hs, o_vs, o_de, o_rgb, o_x_pos, o_y_pos, o_sof, o_eol,
                          o_h_active, o_v_active, o_h_total, o_v_total, o_locked};
          i_rst_n = 1'b1;
          sof_cnt = 0; eol_cnt = 0; e1 = '0; e2 = '0; m_x = '0; m_y = '0;
        end
        @(negedge i_clk);
        if (ln == 5 && h == 2) lk_pre = o_locked;
        if (ln == 5 && h == 3) begin
          lk_post = o_locked; cap_hact = o_h_active; cap_vact = o_v_active;
          cap_htot = o_h_total; cap_vtot = o_v_total;
        end
        sof_cnt += int'(o_sof);
        eol_cnt += int'(o_eol);
        if (o_eol && o_x_pos != 11'(act - 1)) eol_bad++;
        step_model();
        @(posedge i_clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_hs = 1'b1; i_vs = 1'b1; i_de = 1'b0; i_rgb = 24'($urandom);
      cur.hs = 1'b1; cur.vs = 1'b1; cur.de = 1'b0; cur.rgb = '0; cur.x = m_x; cur.y = m_y;
      @(negedge i_clk);
      step_model();
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_chk++; if (|{o_hs, o_vs, o_de, o_rgb, o_x_pos, o_y_pos, o_sof, o_eol} !== 1'b0)
      $display("FAIL reset_stream: got nonzero stream outputs, expected all 0"); else n_pass++;
    n_chk++; if (|{o_h_active, o_v_active, o_h_total, o_v_total} !== 1'b0)
      $display("FAIL reset_meas: got nonzero measurements, expected all 0"); else n_pass++;
    n_chk++; if (o_locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", o_locked); else n_pass++;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1; e1 = '0; e2 = '0; m_x = '0; m_y = '0;
  endtask

  // Four frames from IDLE: geometry published at VS edge 2, lock one cycle after VS edge 4.
  task automatic test_acquire(input string tag);
    run_frame(16, -1, -1);
    run_frame(16, -1, -1);
    n_chk++; if (cap_hact !== 11'd16) $display("FAIL %s_h_active: got %0d expected 16", tag, cap_hact); else n_pass++;
    n_chk++; if (cap_vact !== 11'd4) $display("FAIL %s_v_active: got %0d expected 4", tag, cap_vact); else n_pass++;
    n_chk++; if (cap_htot !== 13'd24) $display("FAIL %s_h_total: got %0d expected 24", tag, cap_htot); else n_pass++;
    n_chk++; if (cap_vtot !== 13'd8) $display("FAIL %s_v_total: got %0d expected 8", tag, cap_vtot); else n_pass++;
    n_chk++; if (lk_post !== 1'b0) $display("FAIL %s_lock_f2: got %b expected 0", tag, lk_post); else n_pass++;
    run_frame(16, -1, -1);
    n_chk++; if (lk_post !== 1'b0) $display("FAIL %s_lock_f3: got %b expected 0", tag, lk_post); else n_pass++;
    run_frame(16, -1, -1);
    n_chk++; if (lk_pre !== 1'b0) $display("FAIL %s_lock_f4_pre: got %b expected 0", tag, lk_pre); else n_pass++;
    n_chk++; if (lk_post !== 1'b1) $display("FAIL %s_lock_f4_post: got %b expected 1", tag, lk_post); else n_pass++;
  endtask

  task automatic test_locked_stream();
    px_chk = 1'b1;
    run_frame(16, -1, -1);
    px_chk = 1'b0;
    n_chk++; if (px_err !== 0) $display("FAIL stream_pixels: got %0d bad cycles expected 0", px_err); else n_pass++;
    n_chk++; if (sof_cnt !== 1) $display("FAIL stream_sof: got %0d pulses expected 1", sof_cnt); else n_pass++;
    n_chk++; if (eol_cnt !== 4) $display("FAIL stream_eol: got %0d pulses expected 4", eol_cnt); else n_pass++;
    n_chk++; if (eol_bad !== 0) $display("FAIL stream_eol_x: got %0d off-position expected 0", eol_bad); else n_pass++;
    n_chk++; if (lk_post !== 1'b1) $display("FAIL stream_locked: got %b expected 1", lk_post); else n_pass++;
  endtask

  task automatic test_bad_line();
    run_frame(16, 2, -1);
    n_chk++; if (lk_pre !== 1'b1) $display("FAIL bad_lock_pre: got %b expected 1", lk_pre); else n_pass++;
    n_chk++; if (lk_post !== 1'b0) $display("FAIL bad_lock_post: got %b expected 0", lk_post); else n_pass++;
    n_chk++; if (cap_hact !== 11'd16) $display("FAIL bad_h_active: got %0d expected 16", cap_hact); else n_pass++;
    run_frame(16, -1, -1);
    n_chk++; if (lk_post !== 1'b0) $display("FAIL bad_relock_1: got %b expected 0", lk_post); else n_pass++;
    run_frame(16, -1, -1);
    n_chk++; if (lk_post !== 1'b1) $display("FAIL bad_relock_2: got %b expected 1", lk_post); else n_pass++;
  endtask

  // The first 20-wide close mixes 24/28 line totals, so the next close still mismatches on h_total.
  task automatic test_res_change();
    run_frame(20, -1, -1);
    n_chk++; if (lk_pre !== 1'b1) $display("FAIL res_lock_pre: got %b expected 1", lk_pre); else n_pass++;
    n_chk++; if (lk_post !== 1'b0) $display("FAIL res_lock_drop: got %b expected 0", lk_post); else n_pass++;
    run_frame(20, -1, -1);
    n_chk++; if (cap_hact !== 11'd20) $display("FAIL res_h_active: got %0d expected 20", cap_hact); else n_pass++;
    n_chk++; if (cap_htot !== 13'd28) $display("FAIL res_h_total: got %0d expected 28", cap_htot); else n_pass++;
    n_chk++; if (cap_vtot !== 13'd8) $display("FAIL res_v_total: got %0d expected 8", cap_vtot); else n_pass++;
    n_chk++; if (lk_post !== 1'b0) $display("FAIL res_lock_b: got %b expected 0", lk_post); else n_pass++;
    run_frame(20, -1, -1);
    n_chk++; if (lk_post !== 1'b0) $display("FAIL res_lock_c: got %b expected 0", lk_post); else n_pass++;
    run_frame(20, -1, -1);
    n_chk++; if (lk_post !== 1'b1) $display("FAIL res_lock_d: got %b expected 1", lk_post); else n_pass++;
  endtask

  task automatic test_watchdog();
    idle(8000);
    n_chk++; if (o_locked !== 1'b1) $display("FAIL wd_before_sat: got %b expected 1", o_locked); else n_pass++;
    idle(300);
    n_chk++; if (o_locked !== 1'b0) $display("FAIL wd_locked: got %b expected 0", o_locked); else n_pass++;
    n_chk++; if (o_h_active !== 11'd0) $display("FAIL wd_h_active: got %0d expected 0", o_h_active); else n_pass++;
    n_chk++; if (o_v_active !== 11'd0) $display("FAIL wd_v_active: got %0d expected 0", o_v_active); else n_pass++;
    n_chk++; if (o_h_total !== 13'd0) $display("FAIL wd_h_total: got %0d expected 0", o_h_total); else n_pass++;
    n_chk++; if (o_v_total !== 13'd0) $display("FAIL wd_v_total: got %0d expected 0", o_v_total); else n_pass++;
    test_acquire("wd");
  endtask

  task automatic test_reset_mid_line();
    run_frame(16, -1, 1);
    n_chk++; if (cap_rst_any !== 1'b0) $display("FAIL rst_outputs: got nonzero outputs expected all 0"); else n_pass++;
    n_chk++; if (sof_cnt !== 0) $display("FAIL rst_no_sof: got %0d pulses expected 0", sof_cnt); else n_pass++;
    px_chk = 1'b1;
    run_frame(16, -1, -1);
    px_chk = 1'b0;
    n_chk++; if (px_err !== 0) $display("FAIL rst_pixels: got %0d bad cycles expected 0", px_err); else n_pass++;
    n_chk++; if (sof_cnt !== 1) $display("FAIL rst_sof: got %0d pulses expected 1", sof_cnt); else n_pass++;
    n_chk++; if (eol_cnt !== 4) $display("FAIL rst_eol: got %0d pulses expected 4", eol_cnt); else n_pass++;
  endtask

  initial begin
    e1 = '0; e2 = '0; cur = '0; m_x = '0; m_y = '0;
    test_reset();
    test_acquire("acq");
    test_locked_stream();
    test_bad_line();
    test_res_change();
    test_watchdog();
    test_reset_mid_line();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
